// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// default word widths and the 2-bit command codes carried in rx_data.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins plus the parallel memory-side handshake of the SPI slave.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
);
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: a route bit picks WRITE / READ_ADD / READ_DATA, then RX_W bits
// are shifted in and strobed out. After a READ_DATA word the block waits for
// tx_valid and shifts TX_W bits of tx_data out on MISO, MSB first.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling route bit (0 write, 1 read addr / read data)
// WRITE     | receiving a write word; idle after completion
// READ_ADD  | receiving a read address; sets rd_addr_flag on completion
// READ_DATA | receiving read command, then wait for tx_valid and shift out
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input logic       clk,
    input logic       rst_n,
    spi_slave_if.slave bus
);

    localparam int TXC_W = $clog2(TX_W + 1);

    spi_state_e      state_q, state_d;
    logic [3:0]      bit_cnt_q;
    logic [RX_W-1:0] shift_q;
    logic [RX_W-1:0] rx_data_q;
    logic            rx_valid_q;
    logic            rd_addr_flag_q;
    logic            frame_done_q;
    logic            tx_wait_q;
    logic            tx_busy_q;
    logic [TX_W-1:0] tx_shift_q;
    logic [TXC_W-1:0] tx_cnt_q;
    logic            miso_q;

    logic ss_exit;
    logic rx_active;
    logic last_bit;

    // Frame-level qualifiers: SS_n release outranks any data activity.
    always_comb begin
        ss_exit   = (state_q != IDLE) && bus.SS_n;
        rx_active = (state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA)
                    && !frame_done_q && !bus.SS_n;
        last_bit  = (bit_cnt_q == 4'(RX_W - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: route on the bit after SS_n falls; any SS_n high returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.SS_n) state_d = CHK_CMD;
            CHK_CMD: begin
                if (bus.SS_n)           state_d = IDLE;
                else if (!bus.MOSI)     state_d = WRITE;
                else if (rd_addr_flag_q) state_d = READ_DATA;
                else                    state_d = READ_ADD;
            end
            default: if (bus.SS_n) state_d = IDLE;
        endcase
    end

    // Receive shifter, word strobe, read-address flag and MISO serializer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            frame_done_q   <= 1'b0;
            tx_wait_q      <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (ss_exit) begin
                // partial frame is dropped; rx_data and rd_addr_flag survive
                bit_cnt_q    <= '0;
                shift_q      <= '0;
                frame_done_q <= 1'b0;
                tx_wait_q    <= 1'b0;
                tx_busy_q    <= 1'b0;
                tx_shift_q   <= '0;
                tx_cnt_q     <= '0;
                miso_q       <= 1'b0;
            end else if (rx_active) begin
                if (last_bit) begin
                    rx_data_q    <= {shift_q[RX_W-2:0], bus.MOSI};
                    rx_valid_q   <= 1'b1;
                    bit_cnt_q    <= '0;
                    shift_q      <= '0;
                    frame_done_q <= 1'b1;
                    if (state_q == READ_ADD) rd_addr_flag_q <= 1'b1;
                    if (state_q == READ_DATA) begin
                        rd_addr_flag_q <= 1'b0;
                        tx_wait_q      <= 1'b1;
                    end
                end else begin
                    shift_q   <= {shift_q[RX_W-2:0], bus.MOSI};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (tx_wait_q && bus.tx_valid) begin
                miso_q     <= bus.tx_data[TX_W-1];
                tx_shift_q <= {bus.tx_data[TX_W-2:0], 1'b0};
                tx_cnt_q   <= TXC_W'(TX_W - 1);
                tx_wait_q  <= 1'b0;
                tx_busy_q  <= 1'b1;
            end else if (tx_busy_q) begin
                if (tx_cnt_q != '0) begin
                    miso_q     <= tx_shift_q[TX_W-1];
                    tx_shift_q <= {tx_shift_q[TX_W-2:0], 1'b0};
                    tx_cnt_q   <= tx_cnt_q - TXC_W'(1);
                end else begin
                    miso_q    <= 1'b0;
                    tx_busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
